mock_uart_tx: RTL
=================

// Module: mock_uart_tx
// PURPOSE
//  Simulation-grade UART transmitter; the driving end of the serial link.
//  Buffers bytes from a testbench/host valid-ready port in a FIFO.
//  Serialises each byte onto tx_sig as start/data/parity/stop, LSB first.
//  Intended to drive the SoC's uart_rx pin in sim_top; frame format matches the existing receive-side mock.
// PARAMETERS
//  BaudRate      9600        line rate, bits/s
//  ParityBit     0           0 none, 1 odd, 2 even
//  DataBitsSize  8           data bits per frame (5..9)
//  StopBitsSize  1           stop bits (1 or 2)
//  BufferSize    128         FIFO depth in entries (power of 2)
//  ClockFreqHz   `CLK_FREQ   clk frequency, Hz
// PORTS
//  clk       in   1                           system clock
//  rst       in   1                           async reset, active-high
//  wr_valid  in   1                           byte offered
//  wr_data   in   DataBitsSize                byte to send
//  wr_ready  out  1                           FIFO can accept (!full)
//  tx_sig    out  1                           serial line, idle high
//  busy      out  1                           frame in progress or FIFO non-empty
//  level     out  $clog2(BufferSize+1)        FIFO occupancy
//  tx_done   out  1                           1-cycle pulse at end of last stop bit
// BEHAVIOUR
//  Reset is asynchronous and active-high, on port rst; clk is the only clock.
//  Reset (async): tx_sig=1, wr_ready=1, busy=0, level=0, tx_done=0, FIFO emptied, FSM=IDLE.
//  Reset asserted mid-frame: line returns high immediately; the partial frame is dropped.
//  ClksPerBit = ClockFreqHz/BaudRate, truncated; elaboration $error if < 2.
//  Push on rising clk when wr_valid && wr_ready. wr_ready depends on full only.
//  When full, a pop in the same cycle does not enable a push.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE|START.
//   - IDLE: tx_sig=1. If FIFO non-empty: pop into shift register, go to START.
//   - START: tx_sig=0 for ClksPerBit cycles.
//   - DATA: shift reg LSB out, ClksPerBit cycles per bit, DataBitsSize bits.
//   - PARITY (skipped if ParityBit==0): odd -> ~^data, even -> ^data.
//   - STOP: tx_sig=1 for StopBitsSize*ClksPerBit cycles.
//  tx_done pulses on the final STOP cycle.
//  On that cycle, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
//  Latency: push at edge N into empty FIFO, FSM idle -> tx_sig falls at edge N+2.
//  Frame length = (1+DataBitsSize+(ParityBit!=0)+StopBitsSize)*ClksPerBit cycles.
//  Baud counter counts 0..ClksPerBit-1 and wraps; bit counter is $clog2(DataBitsSize+1) wide.
//  Simultaneous push and pop: level unchanged; pointers wrap modulo BufferSize.
// CONFIGURATION
//  MOCK_UART_TX_TRACE_EN defined:
//   - $display("mock_uart_tx: sent 0x%02h", byte) on each tx_done.
//   - $error on a push attempt while full (wr_valid && !wr_ready).
//  Not defined: no display and no checks; port list and timing are identical.
// STRUCTURE
//  Package mock_uart_pkg: tx_state_e enum (IDLE, START, DATA, PARITY, STOP); parity constants PARITY_NONE/ODD/EVEN.
//  Sub-module sync_fifo #(Width, Depth): single-clock FIFO with push/pop/full/empty/level and async active-high reset.
//  This module holds the FSM, baud counter, bit counter and shift register.
// TESTING (ClockFreqHz=1_000_000, BaudRate=100_000 -> ClksPerBit=10)
//  1. Push 0xA5, 8N1 -> tx_sig low 2 cycles later, then bits 1,0,1,0,0,1,0,1, then stop.
//     tx_done pulses exactly 100 cycles after tx_sig falls.
//  2. ParityBit=2, push 0x07 -> parity bit 1; ParityBit=1 -> parity bit 0; frame length 110 cycles.
//  3. Push 3 bytes back-to-back -> 3 contiguous frames, no idle cycle between them.
//     level goes 3,2,1,0; busy drops the cycle after the third tx_done.
//  4. BufferSize=4, hold wr_valid with FSM busy -> wr_ready low after 4 accepted.
//     The 5th byte is accepted only after the next pop; no data lost or duplicated.
//  5. Assert rst mid DATA of 0x3C -> tx_sig=1 and level=0 immediately.
//     After release, push 0x55 -> a clean frame of 0x55 only.
//  6. Loopback into mock_uart_rx (9600 baud, 2 stop bits): 128 random bytes received in order.

Source files
------------

// File: rtl/mock_uart_pkg.sv
// rtl/mock_uart_pkg.sv - shared FSM state type and parity-mode constants for the mock UART transmitter.
package mock_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; the head entry is readable combinationally while not empty.
module sync_fifo #(
  parameter int  Width  = 8,
  parameter int  Depth  = 128,
  localparam int LevelW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [Width-1:0]  push_data,
  input  logic              pop,
  output logic [Width-1:0]  pop_data,
  output logic              full,
  output logic              empty,
  output logic [LevelW-1:0] level
);

  localparam int AddrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == LevelW'(Depth));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when the same cycle pops.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mock_uart_tx.sv
// rtl/mock_uart_tx.sv - simulation-grade UART transmitter: FIFO-buffered bytes sent as start/data/parity/stop frames.
// Define MOCK_UART_TX_TRACE_EN for a log line per sent byte and an error on push attempts while full.
`ifndef CLK_FREQ
`define CLK_FREQ 50_000_000
`endif

module mock_uart_tx #(
  parameter int  BaudRate     = 9600,
  parameter int  ParityBit    = 0,
  parameter int  DataBitsSize = 8,
  parameter int  StopBitsSize = 1,
  parameter int  BufferSize   = 128,
  parameter int  ClockFreqHz  = `CLK_FREQ,
  localparam int LevelW       = $clog2(BufferSize + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [DataBitsSize-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    tx_sig,
  output logic                    busy,
  output logic [LevelW-1:0]       level,
  output logic                    tx_done
);

  import mock_uart_pkg::*;

  localparam int ClksPerBit = clks_per_bit(ClockFreqHz, BaudRate);
  localparam int BaudW      = $clog2((ClksPerBit < 2) ? 2 : ClksPerBit);
  localparam int BitW       = $clog2(DataBitsSize + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataBitsSize - 1);
  localparam logic             StopLast = (StopBitsSize == 2);

  if (ClksPerBit < 2) begin : g_rate_check
    $error("mock_uart_tx: ClockFreqHz/BaudRate must give at least 2 clocks per bit");
  end

  if (DataBitsSize < 5 || DataBitsSize > 9 || StopBitsSize < 1 || StopBitsSize > 2) begin : g_format_check
    $error("mock_uart_tx: unsupported frame format");
  end

  tx_state_e               state_q, state_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic [DataBitsSize-1:0] shift_q, shift_d;
  logic [DataBitsSize-1:0] data_q, data_d;
  logic                    tx_sig_q, tx_sig_d;
  logic                    tx_done_q, tx_done_d;
  logic                    busy_q, busy_d;

  logic                    fifo_pop, fifo_full, fifo_empty;
  logic [DataBitsSize-1:0] fifo_data;
  logic                    baud_last, parity_bit;

  sync_fifo #(
    .Width(DataBitsSize),
    .Depth(BufferSize)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_valid),
    .push_data(wr_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign wr_ready   = !fifo_full;
  assign tx_sig     = tx_sig_q;
  assign tx_done    = tx_done_q;
  assign busy       = busy_q;
  assign baud_last  = (baud_q == BaudLast);
  assign parity_bit = (ParityBit == PARITY_ODD) ? ~^data_q : ^data_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    data_d    = data_q;
    fifo_pop  = 1'b0;
    tx_sig_d  = 1'b1;
    tx_done_d = 1'b0;
    busy_d    = (state_q != IDLE) || !fifo_empty;

    if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_data;
          shift_d  = fifo_data;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_sig_d = 1'b0;
        if (baud_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_sig_d = shift_q[0];
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitLast) begin
            stop_d  = 1'b0;
            state_d = (ParityBit != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        tx_sig_d = parity_bit;
        if (baud_last) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        tx_sig_d = 1'b1;
        if (baud_last) begin
          if (stop_q == StopLast) begin
            tx_done_d = 1'b1;
            // Chain straight into the next frame so queued bytes leave no idle gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              data_d   = fifo_data;
              shift_d  = fifo_data;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line, done and busy are registered, so the wire trails the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      tx_sig_q  <= 1'b1;
      tx_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      tx_sig_q  <= tx_sig_d;
      tx_done_q <= tx_done_d;
      busy_q    <= busy_d;
    end
  end

`ifdef MOCK_UART_TX_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && tx_done_d) $display("mock_uart_tx: sent 0x%02h", data_q);
    if (!rst && wr_valid && !wr_ready) $error("mock_uart_tx: push attempted while FIFO full");
  end
`else
  // Untraced build: no logging and no runtime checks.
`endif

endmodule
